// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit sequencer: opcodes,
// next-PC select encodings and the controller state encoding.
package ifu_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned NPC_W = 2;

  localparam logic [OP_W-1:0] OP_J    = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OP_W-1:0] OP_HALT = 6'h3F;

  localparam logic [NPC_W-1:0] NPC_SEQ = 2'b00;
  localparam logic [NPC_W-1:0] NPC_BEQ = 2'b01;
  localparam logic [NPC_W-1:0] NPC_JMP = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_UPDATE,
    S_HALT,
    S_ERR
  } state_e;

endpackage

// File: rtl/ifu_seq_ctrl_if.sv
// Handshake bundle between the sequencer and the ifu / imem / datapath.
// The step input exists only when IFU_SEQ_STEP_EN is defined.
interface ifu_seq_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
`ifdef IFU_SEQ_STEP_EN
  logic             step;
`endif
  logic             imem_ack;
  logic [5:0]       ir_op;
  logic             ex_done;
  logic             zero;
  logic             imem_req;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       npc_sel;
  logic             br_zero;
  logic             busy;
  logic             halted;
  logic             fetch_err;
  logic [CNT_W-1:0] retired;

  // Controller side
  modport master (
`ifdef IFU_SEQ_STEP_EN
    input  step,
`endif
    input  run, imem_ack, ir_op, ex_done, zero,
    output imem_req, ir_we, pc_we, npc_sel, br_zero, busy, halted,
           fetch_err, retired
  );

  // Environment side
  modport slave (
`ifdef IFU_SEQ_STEP_EN
    output step,
`endif
    output run, imem_ack, ir_op, ex_done, zero,
    input  imem_req, ir_we, pc_we, npc_sel, br_zero, busy, halted,
           fetch_err, retired
  );
endinterface

// File: rtl/ifu_seq_ctrl_fetch_timer.sv
// Loadable / clearable up-counter with a terminal-count flag, used to bound
// how long the sequencer waits in FETCH for an imem acknowledge.
module fetch_timer #(
  parameter int unsigned TMR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             inc,
  input  logic [TMR_W-1:0] limit,
  output logic [TMR_W-1:0] count,
  output logic             tc
);

  logic [TMR_W-1:0] count_q;

  // Counter register: clear has priority over load, load over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (inc) begin
      count_q <= count_q + TMR_W'(1);
    end
  end

  assign count = count_q;
  assign tc    = (count_q == limit);

endmodule

// File: rtl/ifu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/update sequencer for the ifu.
// Optional single-step mode: define IFU_SEQ_STEP_EN.
module ifu_seq_ctrl
  import ifu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int unsigned TMR_W       = 4,
  parameter int unsigned CNT_W       = 16
) (
  input logic            clk,
  input logic            reset,
  ifu_seq_ctrl_if.master bus
);

  state_e             state_q, state_d;
  logic [NPC_W-1:0]   npc_sel_q, npc_sel_d;
  logic               br_zero_q, br_zero_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               imem_req_q, pc_we_q, busy_q, halted_q, fetch_err_q;
  logic               ir_we_c;
  logic               tmr_clr, tmr_inc, tmr_tc;
  logic [TMR_W-1:0]   tmr_count;

  fetch_timer #(
    .TMR_W (TMR_W)
  ) u_fetch_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ({TMR_W{1'b0}}),
    .inc      (tmr_inc),
    .limit    (TMR_W'(TIMEOUT_CYC - 1)),
    .count    (tmr_count),
    .tc       (tmr_tc)
  );

  // State, datapath-facing holds and Moore outputs (decoded from next state)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      npc_sel_q   <= NPC_SEQ;
      br_zero_q   <= 1'b0;
      retired_q   <= '0;
      imem_req_q  <= 1'b0;
      pc_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      npc_sel_q   <= npc_sel_d;
      br_zero_q   <= br_zero_d;
      retired_q   <= retired_d;
      imem_req_q  <= (state_d == S_FETCH);
      pc_we_q     <= (state_d == S_UPDATE);
      busy_q      <= !(state_d inside {S_IDLE, S_HALT, S_ERR});
      halted_q    <= (state_d == S_HALT);
      fetch_err_q <= (state_d == S_ERR);
    end
  end

  // Next-state, register updates, timer control and the ir_we strobe
  always_comb begin
    state_d   = state_q;
    npc_sel_d = npc_sel_q;
    br_zero_d = br_zero_q;
    retired_d = retired_q;
    ir_we_c   = 1'b0;
    tmr_clr   = 1'b1;
    tmr_inc   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
`ifdef IFU_SEQ_STEP_EN
        if (bus.run && bus.step) state_d = S_FETCH;
`else
        if (bus.run) state_d = S_FETCH;
`endif
      end

      S_FETCH: begin
        ir_we_c = bus.imem_ack;
        // An ack on the terminal-count cycle still wins over the timeout
        if (bus.imem_ack) begin
          state_d = S_DECODE;
        end else begin
          tmr_clr = 1'b0;
          tmr_inc = 1'b1;
          if (tmr_tc) state_d = S_ERR;
        end
      end

      S_DECODE: begin
        if (bus.ir_op == OP_HALT) begin
          state_d = S_HALT;
        end else if (bus.ir_op == OP_J) begin
          npc_sel_d = NPC_JMP;
          state_d   = S_UPDATE;
        end else if (bus.ir_op == OP_BEQ) begin
          npc_sel_d = NPC_BEQ;
          state_d   = S_EXEC;
        end else begin
          npc_sel_d = NPC_SEQ;
          state_d   = S_EXEC;
        end
      end

      S_EXEC: begin
        if (bus.ex_done) begin
          br_zero_d = (npc_sel_q == NPC_BEQ) && bus.zero;
          state_d   = S_UPDATE;
        end
      end

      S_UPDATE: begin
        retired_d = retired_q + CNT_W'(1);
`ifdef IFU_SEQ_STEP_EN
        state_d = S_IDLE;
`else
        state_d = bus.run ? S_FETCH : S_IDLE;
`endif
      end

      S_HALT: state_d = S_HALT;

      S_ERR: state_d = S_ERR;

      default: state_d = S_IDLE;
    endcase
  end

  // The timer value itself is only observed through its terminal count
  logic unused_tmr;
  assign unused_tmr = ^tmr_count;

  assign bus.imem_req  = imem_req_q;
  assign bus.ir_we     = ir_we_c;
  assign bus.pc_we     = pc_we_q;
  assign bus.npc_sel   = npc_sel_q;
  assign bus.br_zero   = br_zero_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.fetch_err = fetch_err_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_ifu_seq_ctrl.sv
// Scoreboard bench for ifu_seq_ctrl: the driver pushes the expected retirement
// record for every instruction it issues; a negedge monitor pops one record per
// pc_we pulse. A second instance with CNT_W=2 shares the stimulus to exercise
// counter wrap.
module tb_ifu_seq_ctrl;
  import ifu_pkg::*;

  typedef struct {
    int         cyc;
    logic [1:0] npc;
    logic       brz;
    int         ret;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   passed;
  int   n_ret;
  logic last_brz;
  exp_t exp_q[$];
  exp_t e_mon;

  ifu_seq_ctrl_if #(.CNT_W(16)) bus ();
  ifu_seq_ctrl_if #(.CNT_W(2))  bus2 ();

  assign bus2.run      = bus.run;
  assign bus2.imem_ack = bus.imem_ack;
  assign bus2.ir_op    = bus.ir_op;
  assign bus2.ex_done  = bus.ex_done;
  assign bus2.zero     = bus.zero;
`ifdef IFU_SEQ_STEP_EN
  assign bus2.step     = bus.step;
`endif

  ifu_seq_ctrl #(.TIMEOUT_CYC(15), .TMR_W(4), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ifu_seq_ctrl #(.TIMEOUT_CYC(15), .TMR_W(4), .CNT_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation per pc_we cycle; ir_we must track FETCH on ack
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.pc_we) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_pc_we: got pc_we=1 expected no retirement (cycle %0d)", cyc);
        end else begin
          e_mon = exp_q.pop_front();
          chk("update_cycle", cyc, e_mon.cyc);
          chk("npc_sel", bus.npc_sel, e_mon.npc);
          chk("br_zero", bus.br_zero, e_mon.brz);
          chk("retired", bus.retired, e_mon.ret % 65536);
          chk("retired_w2", bus2.retired, e_mon.ret % 4);
          chk("pc_we_w2", bus2.pc_we, 1);
        end
      end
      if (bus.imem_ack) chk("ir_we_vs_fetch", bus.ir_we, bus.imem_req);
    end
  end

  task automatic wait_req(output bit ok);
    bus.imem_ack = 1'b0;
    bus.ex_done  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      total++;
      $display("FAIL wait_imem_req: got imem_req=0 expected 1 within 40 cycles");
    end
  endtask

  // One instruction: ack after d empty FETCH cycles, ex_done after e EXEC waits
  task automatic do_instr(input logic [5:0] op, input int d, input int e,
                          input logic z, input bit drop_run);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    for (int i = 0; i < d; i++) begin
      bus.imem_ack = 1'b0;
      bus.ex_done  = 1'($urandom_range(0, 1));
      bus.zero     = 1'($urandom_range(0, 1));
      tick();
    end
    bus.imem_ack = 1'b1;
    bus.ir_op    = op;
    bus.ex_done  = 1'($urandom_range(0, 1));
    if (op == OP_J) begin
      exp_q.push_back('{cyc + 2, NPC_JMP, last_brz, n_ret});
      n_ret++;
    end
    tick();
    // DECODE: stray ack / ex_done / zero must be ignored
    bus.imem_ack = 1'($urandom_range(0, 1));
    bus.ex_done  = (op == OP_J) ? 1'b1 : 1'($urandom_range(0, 1));
    bus.zero     = 1'($urandom_range(0, 1));
    if (drop_run) bus.run = 1'b0;
    tick();
    bus.ir_op = 6'($urandom);
    if (op == OP_HALT) begin
      bus.imem_ack = 1'b0;
      bus.ex_done  = 1'b0;
      return;
    end
    if (op != OP_J) begin
      for (int i = 0; i < e; i++) begin
        bus.ex_done  = 1'b0;
        bus.zero     = 1'($urandom_range(0, 1));
        bus.imem_ack = 1'($urandom_range(0, 1));
        tick();
      end
      bus.ex_done  = 1'b1;
      bus.zero     = z;
      bus.imem_ack = 1'($urandom_range(0, 1));
      last_brz     = (op == OP_BEQ) ? z : 1'b0;
      exp_q.push_back('{cyc + 1, (op == OP_BEQ) ? NPC_BEQ : NPC_SEQ, last_brz, n_ret});
      n_ret++;
      tick();
    end
    // UPDATE: stray inputs again
    bus.imem_ack = 1'($urandom_range(0, 1));
    bus.ex_done  = 1'($urandom_range(0, 1));
    tick();
    bus.imem_ack = 1'b0;
    bus.ex_done  = 1'b0;
`ifndef IFU_SEQ_STEP_EN
    if (bus.run) chk("refetch_after_update", bus.imem_req, 1);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_imem_req"}, bus.imem_req, 0);
    chk({tag, "_ir_we"}, bus.ir_we, 0);
    chk({tag, "_pc_we"}, bus.pc_we, 0);
    chk({tag, "_npc_sel"}, bus.npc_sel, 0);
    chk({tag, "_br_zero"}, bus.br_zero, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_halted"}, bus.halted, 0);
    chk({tag, "_fetch_err"}, bus.fetch_err, 0);
    chk({tag, "_retired"}, bus.retired, 0);
  endtask

  task automatic reset_model();
    n_ret    = 0;
    last_brz = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] op;
    case ($urandom_range(0, 3))
      0: op = 6'h00;
      1: op = OP_BEQ;
      2: op = OP_J;
      default: begin
        op = 6'($urandom);
        while (op == OP_J || op == OP_BEQ || op == OP_HALT) op = 6'($urandom);
      end
    endcase
    return op;
  endfunction

  initial begin
    bit ok;
    total = 0;
    passed = 0;
    reset_model();
    reset        = 1'b1;
    bus.run      = 1'b0;
    bus.imem_ack = 1'b0;
    bus.ir_op    = 6'h00;
    bus.ex_done  = 1'b0;
    bus.zero     = 1'b0;
`ifdef IFU_SEQ_STEP_EN
    bus.step     = 1'b1;
`endif
    repeat (2) tick();
    check_idle_outputs("reset");

    reset   = 1'b0;
    bus.run = 1'b1;
    chk("req_before_first_edge", bus.imem_req, 0);
    tick();
    chk("req_after_release", bus.imem_req, 1);
    chk("busy_in_fetch", bus.busy, 1);

    // Directed: sequential, beq taken / not taken, jump
    do_instr(6'h00, 0, 0, 1'b1, 1'b0);
    do_instr(OP_BEQ, 0, 0, 1'b1, 1'b0);
    do_instr(OP_BEQ, 1, 2, 1'b0, 1'b0);
    do_instr(OP_BEQ, 0, 0, 1'b1, 1'b0);
    do_instr(OP_J, 0, 0, 1'b0, 1'b0);

    // Randomised mix
    for (int k = 0; k < 30; k++)
      do_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'b0);

    // run dropped mid-instruction: finishes, then parks in IDLE
    do_instr(6'h11, 0, 1, 1'b0, 1'b1);
    chk("park_req", bus.imem_req, 0);
    chk("park_busy", bus.busy, 0);
    tick();
    chk("park_req_2", bus.imem_req, 0);
    chk("retired_total", bus.retired, n_ret % 65536);
    chk("retired_wrap_w2", bus2.retired, n_ret % 4);
    bus.run = 1'b1;

    // Ack on the 15th FETCH cycle still decodes normally
    do_instr(6'h00, 14, 0, 1'b0, 1'b0);

    // Reset asserted while waiting in EXEC of a beq
    wait_req(ok);
    bus.imem_ack = 1'b1;
    bus.ir_op    = OP_BEQ;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    tick();
    chk("exec_busy", bus.busy, 1);
    chk("exec_npc_sel", bus.npc_sel, NPC_BEQ);
    #2 reset = 1'b1;
    #1 check_idle_outputs("async_reset");
    reset_model();
    tick();
    reset = 1'b0;
    chk("req_right_after_release", bus.imem_req, 0);
    tick();
    chk("req_one_cycle_after_release", bus.imem_req, 1);

    // Fetch timeout: 15 FETCH cycles without ack
    do_instr(6'h00, 0, 0, 1'b0, 1'b0);
    wait_req(ok);
    for (int i = 0; i < 14; i++) tick();
    chk("tmo_err_before_limit", bus.fetch_err, 0);
    chk("tmo_req_before_limit", bus.imem_req, 1);
    tick();
    chk("tmo_fetch_err", bus.fetch_err, 1);
    chk("tmo_req_dropped", bus.imem_req, 0);
    chk("tmo_busy", bus.busy, 0);
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack = 1'($urandom_range(0, 1));
      bus.ex_done  = 1'($urandom_range(0, 1));
      tick();
      chk("tmo_sticky", bus.fetch_err, 1);
      chk("tmo_no_req", bus.imem_req, 0);
    end

    // Halt opcode: sticky halted even with run high
    reset = 1'b1;
    reset_model();
    tick();
    reset = 1'b0;
    do_instr(6'h00, 0, 0, 1'b0, 1'b0);
    do_instr(OP_HALT, 1, 0, 1'b0, 1'b0);
    chk("halt_flag", bus.halted, 1);
    chk("halt_busy", bus.busy, 0);
    chk("halt_req", bus.imem_req, 0);
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack = 1'($urandom_range(0, 1));
      bus.ex_done  = 1'($urandom_range(0, 1));
      tick();
      chk("halt_sticky", bus.halted, 1);
      chk("halt_no_req", bus.imem_req, 0);
      chk("halt_no_pc_we", bus.pc_we, 0);
    end
    chk("halt_retired", bus.retired, 1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
